// File: rtl/pipe_preif_if.sv
// Pre-IF bus bundle: instruction-SRAM request channel plus the
// valid/allowin handoff to the IF stage (master = pre-IF side).
interface pipe_preif_if;
    logic        from_allowin;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        to_valid;
    logic [31:0] to_pc;
    logic        inst_discard;

    modport master (
        input  from_allowin,
        input  inst_sram_addr_ok,
        output inst_sram_req,
        output inst_sram_addr,
        output to_valid,
        output to_pc,
        output inst_discard
    );

    modport slave (
        output from_allowin,
        output inst_sram_addr_ok,
        input  inst_sram_req,
        input  inst_sram_addr,
        input  to_valid,
        input  to_pc,
        input  inst_discard
    );
endinterface

// File: rtl/pipe_preif.sv
// Pre-IF stage: owns the fetch PC, issues inst-SRAM requests and hands
// accepted PCs to IF. Ports: clk, resetn, bus (pipe_preif_if.master),
// br_taken/br_target, flush_WB/flush_target redirect inputs.
module pipe_preif #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic         clk,
    input  logic         resetn,
    pipe_preif_if.master bus,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    input  logic         flush_WB,
    input  logic [31:0]  flush_target
);

    // HOLD: a redirect arrived while the current request was still
    // waiting on addr_ok, so that request is stale once accepted.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        req_hold_q, req_hold_d;

    logic        req;
    logic        hs;
    logic        redir;
    logic [31:0] tgt;

    // Gated by resetn so nothing is requested while reset is held.
    assign req   = resetn & (bus.from_allowin | req_hold_q);
    assign hs    = req & bus.inst_sram_addr_ok;
    assign redir = flush_WB | br_taken;
    assign tgt   = flush_WB ? flush_target : br_target;

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_addr = pc_q;
    assign bus.to_pc          = pc_q;
    assign bus.to_valid       = hs & ~redir & (state_q == RUN);
    assign bus.inst_discard   = hs & (redir | (state_q == HOLD));

    // A raised request stays up (with a frozen address) until accepted.
    assign req_hold_d = req & ~bus.inst_sram_addr_ok;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            RUN: begin
                if (hs && !redir) begin
                    pc_d = pc_q + 32'd4;
                end else if (redir && (hs || !req)) begin
                    pc_d = tgt;
                end else if (redir) begin
                    // Bus is held: keep the address, park the target.
                    state_d    = HOLD;
                    redir_pc_d = tgt;
                end
            end
            HOLD: begin
                if (hs) begin
                    pc_d    = redir ? tgt : redir_pc_q;
                    state_d = RUN;
                end else if (redir) begin
                    redir_pc_d = tgt;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            redir_pc_q <= 32'h0;
            req_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            req_hold_q <= req_hold_d;
        end
    end

endmodule

// File: tb/tb_pipe_preif.sv
// Self-checking bench for pipe_preif: directed stimulus with a queue of
// expected IF handoff/discard events checked by a negedge monitor.
module tb_pipe_preif;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] pc;
    } ev_t;

    localparam logic [1:0] EV_VALID = 2'b10;
    localparam logic [1:0] EV_DISC  = 2'b01;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush_WB;
    logic [31:0] flush_target;

    int n_vec = 0;
    int n_bad = 0;
    ev_t sb[$];

    pipe_preif_if bus ();

    pipe_preif u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .flush_WB     (flush_WB),
        .flush_target (flush_target)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [1:0] k, logic [31:0] p);
        ev_t e;
        e.kind = k;
        e.pc   = p;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (resetn && (bus.to_valid || bus.inst_discard)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ev", {30'd0, bus.to_valid, bus.inst_discard}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_kind", {30'd0, bus.to_valid, bus.inst_discard}, {30'd0, e.kind});
                chk("ev_pc", bus.to_pc, e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn            = 1'b0;
        bus.from_allowin  = 1'b1;
        bus.inst_sram_addr_ok = 1'b1;
        br_taken          = 1'b1;
        br_target         = 32'h1c0000f0;
        flush_WB          = 1'b0;
        flush_target      = 32'h0;
        cyc();
        cyc();
        chk("rst_req", {31'd0, bus.inst_sram_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.to_valid}, 32'd0);
        chk("rst_disc", {31'd0, bus.inst_discard}, 32'd0);
        chk("rst_addr", bus.inst_sram_addr, 32'h1c000000);
        chk("rst_to_pc", bus.to_pc, 32'h1c000000);

        // Release reset: three back-to-back accepted fetches.
        br_taken = 1'b0;
        resetn   = 1'b1;
        #1;
        chk("first_req", {31'd0, bus.inst_sram_req}, 32'd1);
        chk("first_addr", bus.inst_sram_addr, 32'h1c000000);
        push(EV_VALID, 32'h1c000000);
        push(EV_VALID, 32'h1c000004);
        push(EV_VALID, 32'h1c000008);
        cyc();
        cyc();
        cyc();

        // Backpressure from IF.
        bus.from_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req", {31'd0, bus.inst_sram_req}, 32'd0);
            chk("bp_addr", bus.inst_sram_addr, 32'h1c00000c);
            cyc();
        end
        bus.from_allowin = 1'b1;
        push(EV_VALID, 32'h1c00000c);
        cyc();

        // Stalled request survives allowin dropping.
        bus.inst_sram_addr_ok = 1'b0;
        cyc();
        bus.from_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req", {31'd0, bus.inst_sram_req}, 32'd1);
            chk("stall_addr", bus.inst_sram_addr, 32'h1c000010);
            cyc();
        end
        bus.inst_sram_addr_ok = 1'b1;
        push(EV_VALID, 32'h1c000010);
        cyc();

        // Branch while request pending: stale response discarded.
        bus.from_allowin      = 1'b1;
        bus.inst_sram_addr_ok = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h1c000100;
        cyc();
        br_taken = 1'b0;
        #1;
        chk("hold_addr", bus.inst_sram_addr, 32'h1c000014);
        cyc();
        bus.inst_sram_addr_ok = 1'b1;
        push(EV_DISC, 32'h1c000014);
        cyc();
        chk("redir_addr", bus.inst_sram_addr, 32'h1c000100);
        push(EV_VALID, 32'h1c000100);
        cyc();

        // Flush and branch together with handshake: flush wins.
        flush_WB     = 1'b1;
        flush_target = 32'h1c008000;
        br_taken     = 1'b1;
        br_target    = 32'h1c000200;
        push(EV_DISC, 32'h1c000104);
        cyc();
        flush_WB = 1'b0;
        br_taken = 1'b0;
        chk("flush_addr", bus.inst_sram_addr, 32'h1c008000);
        push(EV_VALID, 32'h1c008000);
        cyc();

        // Two redirects in HOLD: the latest target wins.
        bus.inst_sram_addr_ok = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h1c000300;
        cyc();
        br_target = 32'h1c000400;
        cyc();
        br_taken = 1'b0;
        bus.inst_sram_addr_ok = 1'b1;
        push(EV_DISC, 32'h1c008004);
        cyc();
        chk("ovr_addr", bus.inst_sram_addr, 32'h1c000400);
        push(EV_VALID, 32'h1c000400);
        cyc();

        // Redirect with no request outstanding goes straight to pc.
        bus.from_allowin = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h1c000500;
        cyc();
        br_taken = 1'b0;
        chk("idle_redir_addr", bus.inst_sram_addr, 32'h1c000500);
        chk("idle_redir_req", {31'd0, bus.inst_sram_req}, 32'd0);

        // Wrap at the top of the address space.
        br_taken  = 1'b1;
        br_target = 32'hfffffffc;
        cyc();
        br_taken = 1'b0;
        bus.from_allowin = 1'b1;
        push(EV_VALID, 32'hfffffffc);
        cyc();
        chk("wrap_addr", bus.inst_sram_addr, 32'h00000000);
        push(EV_VALID, 32'h00000000);
        cyc();

        // Reset while HOLD with request outstanding.
        bus.inst_sram_addr_ok = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h1c000700;
        cyc();
        br_taken = 1'b0;
        resetn   = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bus.inst_sram_req}, 32'd0);
        chk("mid_rst_addr", bus.inst_sram_addr, 32'h1c000000);
        cyc();
        resetn = 1'b1;
        bus.inst_sram_addr_ok = 1'b1;
        push(EV_VALID, 32'h1c000000);
        cyc();
        bus.from_allowin = 1'b0;
        cyc();
        cyc();
        chk("sb_left", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
